// File: rtl/rv32_ctrl_pkg.sv
// Shared control-path types for the RV32I core: decoded control bundle,
// opcode encodings and EX operand forwarding selects.
package rv32_ctrl_pkg;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       mux_reg_wr;
        logic [1:0] ula_op;
        logic [1:0] alu_src1;
        logic [1:0] alu_src2;
        logic       branch;
        logic       jump;
        logic       jalr;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

endpackage

// File: rtl/ctrl_pipe_hazard.sv
// Combinational hazard unit: load-use and ID-branch/jalr operand stalls,
// plus EX operand forwarding selects (MEM result has priority over WB).
module hazard_unit
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic                  id_branch,
    input  logic                  id_jalr,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  flush_ex_i,
    input  logic                  ex_valid,
    input  logic                  ex_mem_rd,
    input  logic                  ex_reg_wr,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  mem_valid,
    input  logic                  mem_mem_rd,
    input  logic                  mem_reg_wr,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_wr,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall_o,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic load_use, br_ex, br_mem;
    fwd_e sel_a, sel_b;

    always_comb begin
        ex_m1    = ex_valid && (ex_rd != '0) && (ex_rd == id_rs1);
        ex_m2    = ex_valid && (ex_rd != '0) && (ex_rd == id_rs2);
        mem_m1   = mem_valid && (mem_rd != '0) && (mem_rd == id_rs1);
        mem_m2   = mem_valid && (mem_rd != '0) && (mem_rd == id_rs2);
        load_use = ex_mem_rd && (ex_m1 || ex_m2);
        // jalr only reads rs1; branches compare both operands in ID
        br_ex    = ex_reg_wr && ((id_branch && (ex_m1 || ex_m2)) || (id_jalr && ex_m1));
        br_mem   = mem_mem_rd && ((id_branch && (mem_m1 || mem_m2)) || (id_jalr && mem_m1));
        stall_o  = id_valid && !flush_ex_i && (load_use || br_ex || br_mem);

        sel_a = FWD_REG;
        if (mem_valid && mem_reg_wr && (mem_rd != '0) && (mem_rd == ex_rs1))
            sel_a = FWD_MEM;
        else if (wb_valid && wb_reg_wr && (wb_rd != '0) && (wb_rd == ex_rs1))
            sel_a = FWD_WB;

        sel_b = FWD_REG;
        if (mem_valid && mem_reg_wr && (mem_rd != '0) && (mem_rd == ex_rs2))
            sel_b = FWD_MEM;
        else if (wb_valid && wb_reg_wr && (wb_rd != '0) && (wb_rd == ex_rs2))
            sel_b = FWD_WB;
    end

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline registers with hazard stall and forwarding.
// Optional perf counters built only with CTRL_PIPE_PERF_EN defined.
module ctrl_pipe
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_mem_rd,
    input  logic                  id_mem_wr,
    input  logic                  id_reg_wr,
    input  logic                  id_mux_reg_wr,
    input  logic [1:0]            id_ula_op,
    input  logic [1:0]            id_alu_src1,
    input  logic [1:0]            id_alu_src2,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  id_jalr,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  flush_ex_i,
    output logic                  stall_o,
    output logic                  ex_valid,
    output logic [1:0]            ex_ula_op,
    output logic [1:0]            ex_alu_src1,
    output logic [1:0]            ex_alu_src2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_valid,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [REG_ADDR_W-1:0] mem_rd_idx,
    output logic                  wb_valid,
    output logic                  wb_reg_wr,
    output logic                  wb_mux_reg_wr,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    ctrl_t                 id_ctrl, ex_ctrl_q;
    logic                  ex_valid_q, ex_bubble;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic                  mem_valid_q, mem_mem_rd_q, mem_mem_wr_q, mem_reg_wr_q, mem_mux_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  wb_valid_q, wb_reg_wr_q, wb_mux_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  unused_ex_ctrl;

    always_comb begin
        id_ctrl            = CTRL_BUBBLE;
        id_ctrl.mem_rd     = id_mem_rd;
        id_ctrl.mem_wr     = id_mem_wr;
        id_ctrl.reg_wr     = id_reg_wr && !id_branch;
        id_ctrl.mux_reg_wr = id_mux_reg_wr;
        id_ctrl.ula_op     = id_ula_op;
        id_ctrl.alu_src1   = id_alu_src1;
        id_ctrl.alu_src2   = id_alu_src2;
        id_ctrl.branch     = id_branch;
        id_ctrl.jump       = id_jump;
        id_ctrl.jalr       = id_jalr;
    end

    assign ex_bubble = !id_valid || stall_o || flush_ex_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= CTRL_BUBBLE;
            ex_rd_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            mem_valid_q  <= 1'b0;
            mem_mem_rd_q <= 1'b0;
            mem_mem_wr_q <= 1'b0;
            mem_reg_wr_q <= 1'b0;
            mem_mux_q    <= 1'b0;
            mem_rd_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_reg_wr_q  <= 1'b0;
            wb_mux_q     <= 1'b0;
            wb_rd_q      <= '0;
        end else begin
            ex_valid_q   <= !ex_bubble;
            ex_ctrl_q    <= ex_bubble ? CTRL_BUBBLE : id_ctrl;
            ex_rd_q      <= ex_bubble ? '0 : id_rd;
            ex_rs1_q     <= ex_bubble ? '0 : id_rs1;
            ex_rs2_q     <= ex_bubble ? '0 : id_rs2;
            mem_valid_q  <= ex_valid_q;
            mem_mem_rd_q <= ex_ctrl_q.mem_rd;
            mem_mem_wr_q <= ex_ctrl_q.mem_wr;
            mem_reg_wr_q <= ex_ctrl_q.reg_wr;
            mem_mux_q    <= ex_ctrl_q.mux_reg_wr;
            mem_rd_q     <= ex_rd_q;
            wb_valid_q   <= mem_valid_q;
            wb_reg_wr_q  <= mem_reg_wr_q;
            wb_mux_q     <= mem_mux_q;
            wb_rd_q      <= mem_rd_q;
        end
    end

    // ID-stage decisions are already taken; these bits end their life in EX
    assign unused_ex_ctrl = ^{ex_ctrl_q.branch, ex_ctrl_q.jump, ex_ctrl_q.jalr};

    hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .id_valid   (id_valid),
        .id_branch  (id_branch),
        .id_jalr    (id_jalr),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .flush_ex_i (flush_ex_i),
        .ex_valid   (ex_valid_q),
        .ex_mem_rd  (ex_ctrl_q.mem_rd),
        .ex_reg_wr  (ex_ctrl_q.reg_wr),
        .ex_rd      (ex_rd_q),
        .ex_rs1     (ex_rs1_q),
        .ex_rs2     (ex_rs2_q),
        .mem_valid  (mem_valid_q),
        .mem_mem_rd (mem_mem_rd_q),
        .mem_reg_wr (mem_reg_wr_q),
        .mem_rd     (mem_rd_q),
        .wb_valid   (wb_valid_q),
        .wb_reg_wr  (wb_reg_wr_q),
        .wb_rd      (wb_rd_q),
        .stall_o    (stall_o),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    assign ex_valid      = ex_valid_q;
    assign ex_ula_op     = ex_ctrl_q.ula_op;
    assign ex_alu_src1   = ex_ctrl_q.alu_src1;
    assign ex_alu_src2   = ex_ctrl_q.alu_src2;
    assign ex_rd         = ex_rd_q;
    assign mem_valid     = mem_valid_q;
    assign mem_rd_o      = mem_mem_rd_q;
    assign mem_wr_o      = mem_mem_wr_q;
    assign mem_rd_idx    = mem_rd_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_wr     = wb_reg_wr_q;
    assign wb_mux_reg_wr = wb_mux_q;
    assign wb_rd         = wb_rd_q;

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_ex_i && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: WB retirements checked against a queue
// filled at issue; EX/MEM stage contents, stalls and forwarding checked per cycle.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr;
    logic [1:0]  id_ula_op, id_alu_src1, id_alu_src2;
    logic        id_branch, id_jump, id_jalr;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic        flush_ex_i;
    logic        stall_o, ex_valid;
    logic [1:0]  ex_ula_op, ex_alu_src1, ex_alu_src2;
    logic [4:0]  ex_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_valid, mem_rd_o, mem_wr_o;
    logic [4:0]  mem_rd_idx;
    logic        wb_valid, wb_reg_wr, wb_mux_reg_wr;
    logic [4:0]  wb_rd;
    logic [31:0] stall_cnt, flush_cnt;

    ctrl_pipe #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr),
        .id_mux_reg_wr(id_mux_reg_wr), .id_ula_op(id_ula_op),
        .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2),
        .id_branch(id_branch), .id_jump(id_jump), .id_jalr(id_jalr),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .flush_ex_i(flush_ex_i),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_ula_op(ex_ula_op),
        .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2), .ex_rd(ex_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_valid(mem_valid), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .mem_rd_idx(mem_rd_idx), .wb_valid(wb_valid),
        .wb_reg_wr(wb_reg_wr), .wb_mux_reg_wr(wb_mux_reg_wr), .wb_rd(wb_rd),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_rd, mem_wr, reg_wr, mux;
        logic [1:0] ula, src1, src2;
        logic       br, jmp, jalr;
        logic [4:0] rd, rs1, rs2;
    } ins_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_sc  = 0;
    int         exp_fc  = 0;
    logic [6:0] sb[$];
    ins_t       e_i = '0, m_i = '0;
    logic       e_v = 1'b0, m_v = 1'b0;
    logic       s_stall;

    function automatic ins_t i_add(input logic [4:0] rd, rs1, rs2);
        ins_t i = '0;
        i.reg_wr = 1'b1; i.ula = 2'b10; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    function automatic ins_t i_addi(input logic [4:0] rd, rs1);
        ins_t i = '0;
        i.reg_wr = 1'b1; i.ula = 2'b10; i.src2 = 2'b01; i.rd = rd; i.rs1 = rs1;
        return i;
    endfunction

    function automatic ins_t i_lw(input logic [4:0] rd, rs1);
        ins_t i = '0;
        i.mem_rd = 1'b1; i.reg_wr = 1'b1; i.mux = 1'b1; i.src2 = 2'b01;
        i.rd = rd; i.rs1 = rs1;
        return i;
    endfunction

    function automatic ins_t i_beq(input logic [4:0] rs1, rs2);
        ins_t i = '0;
        i.br = 1'b1; i.reg_wr = 1'b1; i.ula = 2'b01; i.src1 = 2'b10;
        i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    function automatic ins_t i_jalr(input logic [4:0] rd, rs1, rs2);
        ins_t i = '0;
        i.jalr = 1'b1; i.jmp = 1'b1; i.reg_wr = 1'b1; i.src1 = 2'b01;
        i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    task automatic cyc(input ins_t i, input logic v, input logic fl, input logic exp_stall);
        logic       go;
        logic [6:0] e;
        ins_t       eq;
        id_valid = v; id_mem_rd = i.mem_rd; id_mem_wr = i.mem_wr; id_reg_wr = i.reg_wr;
        id_mux_reg_wr = i.mux; id_ula_op = i.ula; id_alu_src1 = i.src1; id_alu_src2 = i.src2;
        id_branch = i.br; id_jump = i.jmp; id_jalr = i.jalr;
        id_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2; flush_ex_i = fl;
        @(negedge clk);
        s_stall = stall_o;
        n_tests++;
        if (stall_o !== exp_stall) begin
            n_fail++;
            $display("FAIL stall_o got %b exp %b at %0t", stall_o, exp_stall, $time);
        end
        if (wb_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_retire got rd=%0d with empty scoreboard at %0t", wb_rd, $time);
            end else begin
                e = sb.pop_front();
                if ({wb_rd, wb_reg_wr, wb_mux_reg_wr} !== e) begin
                    n_fail++;
                    $display("FAIL wb_retire got {rd,wr,mux}=%h exp %h at %0t",
                             {wb_rd, wb_reg_wr, wb_mux_reg_wr}, e, $time);
                end
            end
        end
        go = v && !exp_stall && !fl;
        if (go) sb.push_back({i.rd, i.reg_wr & ~i.br, i.mux});
        if (exp_stall && !fl) exp_sc++;
        if (fl) exp_fc++;
        @(posedge clk);
        #1;
        m_v = e_v; m_i = e_i;
        e_v = go;  e_i = go ? i : '0;
        eq  = e_i;
        n_tests++;
        if ({ex_valid, ex_rd, ex_ula_op, ex_alu_src1, ex_alu_src2} !==
            {e_v, eq.rd, eq.ula, eq.src1, eq.src2}) begin
            n_fail++;
            $display("FAIL ex_stage got v=%b rd=%0d op=%b s1=%b s2=%b exp v=%b rd=%0d op=%b s1=%b s2=%b",
                     ex_valid, ex_rd, ex_ula_op, ex_alu_src1, ex_alu_src2,
                     e_v, eq.rd, eq.ula, eq.src1, eq.src2);
        end
        n_tests++;
        if ({mem_valid, mem_rd_o, mem_wr_o, mem_rd_idx} !== {m_v, m_i.mem_rd, m_i.mem_wr, m_i.rd}) begin
            n_fail++;
            $display("FAIL mem_stage got %b exp %b",
                     {mem_valid, mem_rd_o, mem_wr_o, mem_rd_idx}, {m_v, m_i.mem_rd, m_i.mem_wr, m_i.rd});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) cyc('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_fwd(input string nm, input logic [1:0] ea, input logic [1:0] eb);
        n_tests++;
        if ({fwd_a, fwd_b} !== {ea, eb}) begin
            n_fail++;
            $display("FAIL %s fwd_a/fwd_b got %b/%b exp %b/%b", nm, fwd_a, fwd_b, ea, eb);
        end
    endtask

    task automatic check_cnt(input string nm);
        logic [31:0] es, ef;
`ifdef CTRL_PIPE_PERF_EN
        es = 32'(exp_sc); ef = 32'(exp_fc);
`else
        es = '0; ef = '0;
`endif
        n_tests++;
        if ({stall_cnt, flush_cnt} !== {es, ef}) begin
            n_fail++;
            $display("FAIL %s counters got stall=%0d flush=%0d exp %0d %0d", nm, stall_cnt, flush_cnt, es, ef);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc_drive_idle();
        id_valid = 1'b1; id_mem_rd = 1'b1; id_rs1 = 5'd5; id_rd = 5'd5;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({ex_valid, mem_valid, wb_valid, stall_o, fwd_a, fwd_b, ex_rd, mem_rd_idx, wb_rd} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got ex=%b mem=%b wb=%b stall=%b fwd=%b%b",
                     ex_valid, mem_valid, wb_valid, stall_o, fwd_a, fwd_b);
        end
        check_cnt("reset");
        cyc_drive_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_drive_idle();
        id_valid = 1'b0; id_mem_rd = 1'b0; id_mem_wr = 1'b0; id_reg_wr = 1'b0;
        id_mux_reg_wr = 1'b0; id_ula_op = '0; id_alu_src1 = '0; id_alu_src2 = '0;
        id_branch = 1'b0; id_jump = 1'b0; id_jalr = 1'b0;
        id_rd = '0; id_rs1 = '0; id_rs2 = '0; flush_ex_i = 1'b0;
    endtask

    task automatic test_load_use();
        cyc(i_lw(5, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_add(6, 5, 1), 1'b1, 1'b0, 1'b1);
        cyc(i_add(6, 5, 1), 1'b1, 1'b0, 1'b0);
        check_fwd("load_use_wb", 2'b01, 2'b00);
        drain();
    endtask

    task automatic test_forward();
        cyc(i_add(5, 1, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_add(7, 1, 5), 1'b1, 1'b0, 1'b0);
        check_fwd("fwd_mem", 2'b00, 2'b10);
        drain();
        cyc(i_add(5, 1, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_addi(0, 0), 1'b1, 1'b0, 1'b0);
        cyc(i_add(7, 1, 5), 1'b1, 1'b0, 1'b0);
        check_fwd("fwd_wb", 2'b00, 2'b01);
        drain();
        // MEM and WB both write x5: MEM must win
        cyc(i_add(5, 1, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_addi(5, 3), 1'b1, 1'b0, 1'b0);
        cyc(i_add(8, 5, 5), 1'b1, 1'b0, 1'b0);
        check_fwd("fwd_prio", 2'b10, 2'b10);
        drain();
    endtask

    task automatic test_x0();
        cyc(i_addi(0, 1), 1'b1, 1'b0, 1'b0);
        cyc(i_add(2, 0, 0), 1'b1, 1'b0, 1'b0);
        check_fwd("x0_nofwd", 2'b00, 2'b00);
        drain();
        cyc(i_lw(0, 1), 1'b1, 1'b0, 1'b0);
        cyc(i_add(2, 0, 0), 1'b1, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_branch();
        cyc(i_add(5, 1, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_beq(5, 6), 1'b1, 1'b0, 1'b1);
        cyc(i_beq(5, 6), 1'b1, 1'b0, 1'b0);
        drain();
        cyc(i_lw(5, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_beq(6, 5), 1'b1, 1'b0, 1'b1);
        cyc(i_beq(6, 5), 1'b1, 1'b0, 1'b1);
        cyc(i_beq(6, 5), 1'b1, 1'b0, 1'b0);
        drain();
        cyc(i_add(5, 1, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_jalr(1, 5, 0), 1'b1, 1'b0, 1'b1);
        cyc(i_jalr(1, 5, 0), 1'b1, 1'b0, 1'b0);
        drain();
        cyc(i_add(5, 1, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_jalr(1, 6, 5), 1'b1, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_flush();
        cyc(i_lw(5, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_add(6, 5, 1), 1'b1, 1'b1, 1'b0);
        check_cnt("flush");
        drain();
    endtask

    task automatic test_back_to_back();
        cyc(i_add(3, 1, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_add(4, 3, 3), 1'b1, 1'b0, 1'b0);
        check_fwd("b2b_1", 2'b10, 2'b10);
        cyc(i_add(9, 3, 4), 1'b1, 1'b0, 1'b0);
        check_fwd("b2b_2", 2'b01, 2'b10);
        drain();
    endtask

    task automatic test_reset_mid();
        cyc(i_add(5, 1, 2), 1'b1, 1'b0, 1'b0);
        cyc(i_lw(6, 2), 1'b1, 1'b0, 1'b0);
        cyc_drive_idle();
        id_valid = 1'b1; id_reg_wr = 1'b1; id_rd = 5'd8; id_rs1 = 5'd6; id_rs2 = 5'd1;
        #2;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_stall got %b exp 1", stall_o);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ex_valid, mem_valid, wb_valid, stall_o, fwd_a, fwd_b, ex_rd, ex_ula_op,
             mem_rd_o, mem_rd_idx, wb_reg_wr, wb_rd} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got ex=%b mem=%b wb=%b stall=%b fwd=%b%b",
                     ex_valid, mem_valid, wb_valid, stall_o, fwd_a, fwd_b);
        end
        sb.delete();
        e_v = 1'b0; m_v = 1'b0; e_i = '0; m_i = '0; exp_sc = 0; exp_fc = 0;
        check_cnt("async_reset");
        cyc_drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_x0();
        test_branch();
        test_flush();
        test_back_to_back();
        check_cnt("pre_reset");
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
